wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage feeding the 32x32 register file write port (write_reg/write_d/reg_write).
//  Takes retiring instructions from MEM over a valid/ready handshake and selects the result (ALU/load/PC+4).
//  Aligns and extends load data, then issues at most one register write per cycle.
//  A 2-entry skid buffer (MAIN, SKID) absorbs a registered hold without combinational ready paths.
// PARAMETERS
//  DATA_W  32  datapath / register width
//  REG_AW  5   register index width (2**REG_AW registers)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  in_valid      in   1       MEM presents an instruction
//  in_ready      out  1       stage accepts this cycle (registered)
//  in_rd         in   REG_AW  destination register
//  in_wen        in   1       instruction writes rd
//  in_wb_sel     in   2       00 ALU, 01 load, 10 PC+4, 11 ALU
//  in_alu_res    in   DATA_W  ALU result
//  in_mem_data   in   DATA_W  raw aligned-word load data
//  in_pc4        in   DATA_W  PC+4 (link value)
//  in_ld_size    in   2       00 word, 01 half, 10 byte, 11 word
//  in_ld_uns     in   1       1 = zero-extend, 0 = sign-extend
//  in_byte_off   in   2       address[1:0] of the load
//  hold          in   1       retire blocked; must come from a flop
//  write_reg     out  REG_AW  register file write index
//  write_d       out  DATA_W  register file write data
//  reg_write     out  1       register file write enable
//  retired_cnt   out  32      count of retired instructions
// BEHAVIOUR
//  - Reset (async, rst_n=0): MAIN.vld=SKID.vld=0; in_ready=1; write_reg=0; write_d=0; reg_write=0; retired_cnt=0.
//  - Accept = in_valid & in_ready. Result is selected and load-aligned before capture; entries hold final data.
//  - Entry fields: {vld, wen_eff, rd, data}; wen_eff = in_wen & (in_rd != 0). r0 is never written.
//  - Load align: byte = mem_data[8*off +: 8]; half = mem_data[16*off[1] +: 16] (off[0] ignored, no trap);
//    sign/zero extend per in_ld_uns.
//  - Outputs: write_reg=MAIN.rd, write_d=MAIN.data, reg_write=MAIN.vld & MAIN.wen_eff & ~hold.
//  - Retire = MAIN.vld & ~hold. Latency: accepted at edge N -> reg_write high during cycle N..N+1 if no hold.
//  - Next state per edge:
//    * SKID.vld & retire: MAIN<=SKID, SKID.vld<=0.
//    * ~SKID.vld & (retire | ~MAIN.vld) & accept: MAIN<=in.
//    * ~SKID.vld & (retire | ~MAIN.vld) & ~accept: MAIN.vld<=0.
//    * MAIN.vld & ~retire & accept: SKID<=in (MAIN unchanged).
//  - in_ready_next = ~SKID.vld_next. SKID full => in_ready=0 (no accept). Never overwrite a valid entry.
//  - Instructions retire in order; no drops or duplicates.
//  - retired_cnt += 1 per retire, including wen_eff=0; it wraps 0xFFFFFFFF->0.
//  - hold for any number of cycles: state frozen except SKID fill; reg_write stays 0.
//  - Reset mid-operation discards both entries; no write is issued.
// CONFIGURATION
//  WB_BYPASS_EN defined: extra outputs byp0_vld/byp0_rd/byp0_data (MAIN) and byp1_vld/byp1_rd/byp1_data (SKID).
//    Each *_vld = entry.vld & entry.wen_eff. Consumer gives SKID (younger) priority over MAIN on rd match.
//  Undefined: bypass ports and logic absent; all other behaviour identical.
// STRUCTURE
//  proc_pkg: WB_SEL_ALU/LOAD/PC4 and LD_SIZE_W/H/B encodings, DATA_W/REG_AW defaults.
//  Sub-module load_align (combinational: mem_data, size, uns, off -> extended data), one instance.
//  Skid control and entry registers stay in wb_stage.
// TESTING
//  1. Reset release, in_valid=0 -> in_ready=1, reg_write=0, retired_cnt=0.
//  2. ALU op: rd=5, alu=0x1234, wen=1 -> next cycle reg_write=1, write_reg=5, write_d=0x1234, cnt=1.
//  3. Loads of mem_data=0x80FF7F01:
//     byte off=1 signed -> 0x0000007F; byte off=2 signed -> 0xFFFFFFFF; half off=2 uns -> 0x000080FF.
//  4. rd=0, wen=1, alu=0xDEAD -> reg_write stays 0; retired_cnt still increments.
//  5. hold=1 with 3 back-to-back offers (rd=1,2,3):
//     2 accepted, in_ready=0; after hold drop writes rd=1 then rd=2, then accepts rd=3.
//  6. retired_cnt preloaded near 0xFFFFFFFF via 2 retires from 0xFFFFFFFE -> wraps to 0;
//     rst_n low mid-hold clears entries, no write.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings and default widths for the processor pipeline stages.
package proc_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_ALT  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_SIZE_W   = 2'b00,
    LD_SIZE_H   = 2'b01,
    LD_SIZE_B   = 2'b10,
    LD_SIZE_ALT = 2'b11
  } ld_size_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks byte/half from the aligned word and extends it.
module load_align
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [1:0]        i_size,
  input  logic              i_uns,
  input  logic [1:0]        i_off,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem_data[7:0];
    case (i_off)
      2'd0:    w_byte = i_mem_data[7:0];
      2'd1:    w_byte = i_mem_data[15:8];
      2'd2:    w_byte = i_mem_data[23:16];
      default: w_byte = i_mem_data[31:24];
    endcase
    // Misaligned halfword just ignores off[0]; no trap is raised here.
    w_half = i_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
  end

  always_comb begin
    o_data = i_mem_data;
    case (ld_size_e'(i_size))
      LD_SIZE_H: o_data = {{(DATA_W-16){~i_uns & w_half[15]}}, w_half};
      LD_SIZE_B: o_data = {{(DATA_W-8){~i_uns & w_byte[7]}}, w_byte};
      default:   o_data = i_mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage with 2-entry skid buffer (MAIN, SKID) and registered in_ready.
// Optional macro WB_BYPASS_EN exposes both entries as forwarding sources.
module wb_stage
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_uns,
  input  logic [1:0]        in_byte_off,
  input  logic              hold,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_d,
  output logic              reg_write,
`ifdef WB_BYPASS_EN
  output logic              byp0_vld,
  output logic [REG_AW-1:0] byp0_rd,
  output logic [DATA_W-1:0] byp0_data,
  output logic              byp1_vld,
  output logic [REG_AW-1:0] byp1_rd,
  output logic [DATA_W-1:0] byp1_data,
`endif
  output logic [31:0]       retired_cnt
);

  logic              r_main_vld, r_main_wen;
  logic [REG_AW-1:0] r_main_rd;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld, r_skid_wen;
  logic [REG_AW-1:0] r_skid_rd;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_ready;
  logic [31:0]       r_retired_cnt;

  logic              w_main_vld_nxt, w_main_wen_nxt;
  logic [REG_AW-1:0] w_main_rd_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic              w_skid_vld_nxt, w_skid_wen_nxt;
  logic [REG_AW-1:0] w_skid_rd_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_in_data;
  logic              w_in_wen;
  logic              w_accept;
  logic              w_retire;

  load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .i_mem_data(in_mem_data),
    .i_size    (in_ld_size),
    .i_uns     (in_ld_uns),
    .i_off     (in_byte_off),
    .o_data    (w_ld_data)
  );

  always_comb begin
    w_in_data = in_alu_res;
    case (wb_sel_e'(in_wb_sel))
      WB_SEL_LOAD: w_in_data = w_ld_data;
      WB_SEL_PC4:  w_in_data = in_pc4;
      default:     w_in_data = in_alu_res;
    endcase
  end

  assign w_in_wen = in_wen & (in_rd != '0);
  assign w_accept = in_valid & r_ready;
  assign w_retire = r_main_vld & ~hold;

  always_comb begin
    w_main_vld_nxt  = r_main_vld;
    w_main_wen_nxt  = r_main_wen;
    w_main_rd_nxt   = r_main_rd;
    w_main_data_nxt = r_main_data;
    w_skid_vld_nxt  = r_skid_vld;
    w_skid_wen_nxt  = r_skid_wen;
    w_skid_rd_nxt   = r_skid_rd;
    w_skid_data_nxt = r_skid_data;
    // A full SKID forces in_ready low, so no accept can coincide with it.
    if (r_skid_vld) begin
      if (w_retire) begin
        w_main_vld_nxt  = 1'b1;
        w_main_wen_nxt  = r_skid_wen;
        w_main_rd_nxt   = r_skid_rd;
        w_main_data_nxt = r_skid_data;
        w_skid_vld_nxt  = 1'b0;
      end
    end else if (w_retire || !r_main_vld) begin
      if (w_accept) begin
        w_main_vld_nxt  = 1'b1;
        w_main_wen_nxt  = w_in_wen;
        w_main_rd_nxt   = in_rd;
        w_main_data_nxt = w_in_data;
      end else begin
        w_main_vld_nxt  = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_vld_nxt  = 1'b1;
      w_skid_wen_nxt  = w_in_wen;
      w_skid_rd_nxt   = in_rd;
      w_skid_data_nxt = w_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld    <= 1'b0;
      r_main_wen    <= 1'b0;
      r_main_rd     <= '0;
      r_main_data   <= '0;
      r_skid_vld    <= 1'b0;
      r_skid_wen    <= 1'b0;
      r_skid_rd     <= '0;
      r_skid_data   <= '0;
      r_ready       <= 1'b1;
      r_retired_cnt <= '0;
    end else begin
      r_main_vld    <= w_main_vld_nxt;
      r_main_wen    <= w_main_wen_nxt;
      r_main_rd     <= w_main_rd_nxt;
      r_main_data   <= w_main_data_nxt;
      r_skid_vld    <= w_skid_vld_nxt;
      r_skid_wen    <= w_skid_wen_nxt;
      r_skid_rd     <= w_skid_rd_nxt;
      r_skid_data   <= w_skid_data_nxt;
      r_ready       <= ~w_skid_vld_nxt;
      if (w_retire) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign in_ready    = r_ready;
  assign write_reg   = r_main_rd;
  assign write_d     = r_main_data;
  assign reg_write   = r_main_vld & r_main_wen & ~hold;
  assign retired_cnt = r_retired_cnt;

`ifdef WB_BYPASS_EN
  // SKID holds the younger instruction; consumers must prefer byp1 on a match.
  assign byp0_vld  = r_main_vld & r_main_wen;
  assign byp0_rd   = r_main_rd;
  assign byp0_data = r_main_data;
  assign byp1_vld  = r_skid_vld & r_skid_wen;
  assign byp1_rd   = r_skid_rd;
  assign byp1_data = r_skid_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes queued on accept, popped on reg_write.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc4;
  logic [1:0]  in_ld_size;
  logic        in_ld_uns;
  logic [1:0]  in_byte_off;
  logic        hold;
  logic [4:0]  write_reg;
  logic [31:0] write_d;
  logic        reg_write;
  logic [31:0] retired_cnt;
`ifdef WB_BYPASS_EN
  logic        byp0_vld, byp1_vld;
  logic [4:0]  byp0_rd, byp1_rd;
  logic [31:0] byp0_data, byp1_data;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_cnt;
  int          n_checks;
  int          n_errors;

  wb_stage #(
    .DATA_W(32),
    .REG_AW(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_wb_sel  (in_wb_sel),
    .in_alu_res (in_alu_res),
    .in_mem_data(in_mem_data),
    .in_pc4     (in_pc4),
    .in_ld_size (in_ld_size),
    .in_ld_uns  (in_ld_uns),
    .in_byte_off(in_byte_off),
    .hold       (hold),
    .write_reg  (write_reg),
    .write_d    (write_d),
    .reg_write  (reg_write),
`ifdef WB_BYPASS_EN
    .byp0_vld   (byp0_vld),
    .byp0_rd    (byp0_rd),
    .byp0_data  (byp0_data),
    .byp1_vld   (byp1_vld),
    .byp1_rd    (byp1_rd),
    .byp1_data  (byp1_data),
`endif
    .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every observed register write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_write !== 1'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: reg_write=%b rd=%0d data=%h, required no write",
                 reg_write, write_reg, write_d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (reg_write !== 1'b1 || write_reg !== e.rd || write_d !== e.d) begin
          n_errors++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   write_reg, write_d, e.rd, e.d);
        end
      end
    end
  end

  task automatic send(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                      input logic [1:0] size, input logic uns, input logic [1:0] off,
                      input logic [31:0] exp_d);
    int unsigned budget;
    logic rdy;
    in_rd = rd; in_wen = wen; in_wb_sel = sel; in_alu_res = alu; in_mem_data = mem;
    in_pc4 = pc4; in_ld_size = size; in_ld_uns = uns; in_byte_off = off;
    in_valid = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (rdy !== 1'b1 && budget < 50);
    if (rdy !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", rdy);
    end else begin
      exp_cnt = exp_cnt + 32'd1;
      if (wen && rd != 5'd0) sb.push_back('{rd: rd, d: exp_d});
    end
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    send(rd, 1'b1, 2'b00, val, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, val);
  endtask

  task automatic drain_and_check(input string name);
    hold = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || retired_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL %s_drain: pending=%0d cnt=%h, required pending=0 cnt=%h",
               name, sb.size(), retired_cnt, exp_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; in_valid = 1'b0;
    in_rd = '0; in_wen = 1'b0; in_wb_sel = '0; in_alu_res = '0; in_mem_data = '0;
    in_pc4 = '0; in_ld_size = '0; in_ld_uns = 1'b0; in_byte_off = '0;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || reg_write !== 1'b0 || retired_cnt !== 32'd0 ||
        write_reg !== 5'd0 || write_d !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state: rdy=%b we=%b cnt=%h rd=%0d d=%h, required 1 0 0 0 0",
               in_ready, reg_write, retired_cnt, write_reg, write_d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    alu_op(5'd5, 32'h0000_1234);
    @(negedge clk);
    n_checks++;
    if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_d !== 32'h1234) begin
      n_errors++;
      $display("FAIL alu_latency: we=%b rd=%0d d=%h, required we=1 rd=5 d=00001234",
               reg_write, write_reg, write_d);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (retired_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL alu_count: cnt=%h, required 00000001", retired_cnt);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz[8]  = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    logic        un[8]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [1:0]  of[8]  = '{2'd1,  2'd2,  2'd2,  2'd0,  2'd0,  2'd3,  2'd3,  2'd0};
    logic [31:0] ex[8]  = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_80FF, 32'h80FF_7F01,
                            32'h0000_7F01, 32'hFFFF_FF80, 32'hFFFF_80FF, 32'h0000_0001};
    for (int i = 0; i < 8; i++) begin
      send(5'(i + 8), 1'b1, 2'b01, 32'hBAD0_0000, 32'h80FF_7F01, 32'h0, sz[i], un[i], of[i], ex[i]);
    end
    send(5'd20, 1'b1, 2'b10, 32'hBAD0_0000, 32'h0, 32'h0000_0100, 2'b00, 1'b0, 2'd0, 32'h0000_0100);
    send(5'd21, 1'b1, 2'b11, 32'hCAFE_F00D, 32'h0, 32'h0000_0100, 2'b00, 1'b0, 2'd0, 32'hCAFE_F00D);
    drain_and_check("loads");
  endtask

  task automatic test_r0();
    alu_op(5'd0, 32'h0000_DEAD);
    @(negedge clk);
    n_checks++;
    if (reg_write !== 1'b0) begin
      n_errors++;
      $display("FAIL r0_write: we=%b, required 0", reg_write);
    end
    drain_and_check("r0");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) begin
      alu_op(5'(i), 32'h1000_0000 + 32'(i * 17));
    end
    drain_and_check("b2b");
  endtask

  task automatic test_hold();
    hold = 1'b1;
    alu_op(5'd1, 32'h0000_0011);
    alu_op(5'd2, 32'h0000_0022);
    in_rd = 5'd3; in_alu_res = 32'h0000_0033; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || reg_write !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_full: rdy=%b we=%b, required rdy=0 we=0", in_ready, reg_write);
      end
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    alu_op(5'd3, 32'h0000_0033);
    drain_and_check("hold");
  endtask

  task automatic test_wrap_and_reset();
    @(negedge clk);
    force dut.r_retired_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_retired_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    n_checks++;
    if (retired_cnt !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL cnt_preload: cnt=%h, required fffffffe", retired_cnt);
    end
    @(posedge clk);
    #1;
    alu_op(5'd9, 32'h0000_0009);
    alu_op(5'd10, 32'h0000_000A);
    drain_and_check("wrap");
    n_checks++;
    if (retired_cnt !== 32'd0) begin
      n_errors++;
      $display("FAIL cnt_wrap: cnt=%h, required 00000000", retired_cnt);
    end

    hold = 1'b1;
    alu_op(5'd7, 32'h0000_0077);
    alu_op(5'd8, 32'h0000_0088);
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    n_checks++;
    if (reg_write !== 1'b0 || in_ready !== 1'b1 || retired_cnt !== 32'd0 ||
        write_reg !== 5'd0 || write_d !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset_state: we=%b rdy=%b cnt=%h rd=%0d d=%h, required 0 1 0 0 0",
               reg_write, in_ready, retired_cnt, write_reg, write_d);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (reg_write !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_nowrite: we=%b, required 0", reg_write);
      end
    end
    drain_and_check("midreset");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_alu();
    test_loads();
    test_r0();
    test_back_to_back();
    test_hold();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
